led_blink_sequencer: RTL and testbench



---
 rtl/led_blink_sequencer_pkg.sv | 25 ++
 rtl/led_blink_sequencer_tick_prescaler.sv | 32 +++
 rtl/led_blink_sequencer.sv | 122 ++++++++++++
 tb/tb_led_blink_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_sequencer_pkg.sv
// Shared definitions for the LED blink sequencer: FSM state encoding and
// width helpers used to size the prescaler and phase counters.
package led_blink_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int w;
    w = 0;
    while ((64'(1) << w) < 64'(value)) begin
      w = w + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_blink_sequencer_tick_prescaler.sv
// Clock-enable prescaler: one-cycle tick every TICK_DIV clocks, restartable
// from zero through a synchronous clear.
module led_blink_sequencer_tick_prescaler
  import led_blink_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = clog2_min1(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || (cnt == CNT_LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With TICK_DIV == 1 the counter sits at zero and tick is permanently high.
  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/led_blink_sequencer.sv
// Turns single-cycle event pulses into visible LED blinks (on-time then dark
// gap), queuing events that arrive mid-blink in a saturating pending counter.
module led_blink_sequencer
  import led_blink_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = 100000,
  parameter int ON_TICKS  = 150,
  parameter int OFF_TICKS = 100,
  parameter int PEND_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              event_i,
  output logic              led,
  output logic              busy,
  output logic              ovf,
  output logic [PEND_W-1:0] pending
);

  localparam int PH_W = clog2_min1(max_int(ON_TICKS, OFF_TICKS));
  localparam logic [PH_W-1:0]   ON_LAST  = PH_W'(ON_TICKS - 1);
  localparam logic [PH_W-1:0]   OFF_LAST = PH_W'(OFF_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t          state;
  logic [PH_W-1:0] phase;
  logic            tick;
  logic            phase_done;
  logic            consume;
  logic            presc_clr;

  // The prescaler is held at zero while idle and restarted on every phase
  // end, so each ON/GAP interval starts on a fresh tick boundary.
  led_blink_sequencer_tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (presc_clr),
    .tick (tick)
  );

  always_comb begin
    phase_done = 1'b0;
    case (state)
      ST_ON:   phase_done = tick && (phase == ON_LAST);
      ST_GAP:  phase_done = tick && (phase == OFF_LAST);
      default: phase_done = 1'b0;
    endcase
    consume   = (pending != '0) &&
                ((state == ST_IDLE) || ((state == ST_GAP) && phase_done));
    presc_clr = (state == ST_IDLE) || phase_done;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      led   <= 1'b0;
      phase <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          phase <= '0;
          if (consume) begin
            state <= ST_ON;
            led   <= 1'b1;
          end
        end
        ST_ON: begin
          if (phase_done) begin
            state <= ST_GAP;
            led   <= 1'b0;
            phase <= '0;
          end else if (tick) begin
            phase <= phase + 1'b1;
          end
        end
        ST_GAP: begin
          if (phase_done) begin
            phase <= '0;
            if (consume) begin
              state <= ST_ON;
              led   <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else if (tick) begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          led   <= 1'b0;
          phase <= '0;
        end
      endcase
    end
  end

  // Increment and consume in the same cycle cancel; an event at saturation
  // is dropped and flagged for exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      ovf <= 1'b0;
      if (event_i && !consume) begin
        if (pending == PEND_MAX) begin
          ovf <= 1'b1;
        end else begin
          pending <= pending + 1'b1;
        end
      end else if (!event_i && consume) begin
        pending <= pending - 1'b1;
      end
    end
  end

  assign busy = (state != ST_IDLE) || (pending != '0);

endmodule

// File: tb/tb_led_blink_sequencer.sv
// Directed bench for led_blink_sequencer: a scaled-down instance for the main
// scenarios plus a TICK_DIV=1 / single-tick corner instance.
module tb_led_blink_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ev_a = 1'b0;
  logic       ev_b = 1'b0;
  logic       led_a, busy_a, ovf_a;
  logic       led_b, busy_b, ovf_b;
  logic [1:0] pend_a, pend_b;

  int cyc = 0;
  int vectors = 0;
  int fails = 0;
  int rises_a = 0;
  int rises_b = 0;
  int ovfs_a = 0;
  int base_rise;
  int base_ovf;
  int stop_at;
  logic led_qa = 1'b0;
  logic led_qb = 1'b0;

  led_blink_sequencer #(
    .TICK_DIV (4), .ON_TICKS (3), .OFF_TICKS (2), .PEND_W (2)
  ) dut_a (
    .clk (clk), .rst (rst), .event_i (ev_a),
    .led (led_a), .busy (busy_a), .ovf (ovf_a), .pending (pend_a)
  );

  led_blink_sequencer #(
    .TICK_DIV (1), .ON_TICKS (1), .OFF_TICKS (1), .PEND_W (2)
  ) dut_b (
    .clk (clk), .rst (rst), .event_i (ev_b),
    .led (led_b), .busy (busy_b), .ovf (ovf_b), .pending (pend_b)
  );

  always #5 clk = ~clk;

  // Running counts of blink starts and overflow pulses.
  always @(posedge clk) begin
    led_qa <= led_a;
    led_qb <= led_b;
    if (led_a && !led_qa) rises_a <= rises_a + 1;
    if (led_b && !led_qb) rises_b <= rises_b + 1;
    if (ovf_a) ovfs_a <= ovfs_a + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic do_reset;
    rst  = 1'b1;
    ev_a = 1'b0;
    ev_b = 1'b0;
    #1;
    check("rst_led_a", led_a, 0);
    check("rst_busy_a", busy_a, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_pend_a", pend_a, 0);
    check("rst_led_b", led_b, 0);
    check("rst_busy_b", busy_b, 0);
    step();
    step();
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    // Single event: ON 12..23, GAP 24..31, idle from 32.
    do_reset();
    run_to(10);
    ev_a = 1'b1;
    step();
    ev_a = 1'b0;
    check("s1_pend_11", pend_a, 1);
    while (cyc <= 34) begin
      check("s1_led", led_a, (cyc >= 12 && cyc <= 23));
      check("s1_busy", busy_a, (cyc >= 11 && cyc <= 31));
      if (cyc == 12) check("s1_pend_12", pend_a, 0);
      step();
    end

    // Three back-to-back events: blinks start at 12, 32, 52.
    do_reset();
    base_rise = rises_a;
    base_ovf  = ovfs_a;
    run_to(10);
    ev_a = 1'b1;
    run_to(12);
    check("s2_pend_12", pend_a, 1);
    check("s2_led_12", led_a, 1);
    step();
    ev_a = 1'b0;
    check("s2_pend_13", pend_a, 2);
    run_to(31);
    check("s2_led_31", led_a, 0);
    step();
    check("s2_pend_32", pend_a, 1);
    check("s2_led_32", led_a, 1);
    run_to(51);
    check("s2_led_51", led_a, 0);
    step();
    check("s2_pend_52", pend_a, 0);
    check("s2_led_52", led_a, 1);
    run_to(75);
    check("s2_blinks", rises_a - base_rise, 3);
    check("s2_ovfs", ovfs_a - base_ovf, 0);
    check("s2_busy_end", busy_a, 0);

    // Saturation: events 10 and 14..17, the one in 17 is dropped.
    do_reset();
    base_rise = rises_a;
    base_ovf  = ovfs_a;
    run_to(10);
    ev_a = 1'b1;
    step();
    ev_a = 1'b0;
    run_to(14);
    ev_a = 1'b1;
    run_to(15);
    check("s3_pend_15", pend_a, 1);
    run_to(17);
    check("s3_pend_17", pend_a, 3);
    check("s3_ovf_17", ovf_a, 0);
    step();
    ev_a = 1'b0;
    check("s3_ovf_18", ovf_a, 1);
    check("s3_pend_18", pend_a, 3);
    step();
    check("s3_ovf_19", ovf_a, 0);
    run_to(100);
    check("s3_blinks", rises_a - base_rise, 4);
    check("s3_ovfs", ovfs_a - base_ovf, 1);
    check("s3_busy_end", busy_a, 0);

    // Event while IDLE consumes: pending stays 1 across the IDLE->ON step.
    do_reset();
    base_rise = rises_a;
    run_to(10);
    ev_a = 1'b1;
    step();
    check("s4_pend_11", pend_a, 1);
    check("s4_led_11", led_a, 0);
    step();
    ev_a = 1'b0;
    check("s4_pend_12", pend_a, 1);
    check("s4_led_12", led_a, 1);
    run_to(60);
    check("s4_blinks", rises_a - base_rise, 2);
    check("s4_busy_end", busy_a, 0);

    // Asynchronous reset mid-ON with two events queued.
    do_reset();
    run_to(10);
    ev_a = 1'b1;
    run_to(13);
    ev_a = 1'b0;
    run_to(17);
    check("s5_pend_17", pend_a, 2);
    check("s5_led_17", led_a, 1);
    rst = 1'b1;
    #1;
    check("s5_led_rst", led_a, 0);
    check("s5_pend_rst", pend_a, 0);
    check("s5_busy_rst", busy_a, 0);
    step();
    step();
    rst = 1'b0;
    base_rise = rises_a;
    stop_at = cyc + 60;
    run_to(stop_at);
    check("s5_blinks_after", rises_a - base_rise, 0);
    check("s5_busy_after", busy_a, 0);
    check("s5_led_after", led_a, 0);

    // TICK_DIV=1 corner: led only in cycle 7, busy 6..8.
    do_reset();
    base_rise = rises_b;
    run_to(5);
    ev_b = 1'b1;
    step();
    ev_b = 1'b0;
    check("s6_pend_6", pend_b, 1);
    while (cyc <= 11) begin
      check("s6_led", led_b, (cyc == 7));
      check("s6_busy", busy_b, (cyc >= 6 && cyc <= 8));
      check("s6_ovf", ovf_b, 0);
      step();
    end
    check("s6_blinks", rises_b - base_rise, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
